// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// rf_wb_pkg : shared widths and grant encoding for the register-file write-back path
// Revision  : 1.0
// ============================================================================
package rf_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

  function automatic grant_e other_grant(input grant_e g);
    return (g == GNT_A) ? GNT_B : GNT_A;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// rf_scoreboard : pending-result tracker for long-latency writes (RF_WB_SB_CHECK_EN adds sb_err)
// Revision      : 1.0
// ============================================================================
module rf_scoreboard
  import rf_wb_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_iss_valid,
  input  logic [AW-1:0] i_iss_rd,
  output logic          o_iss_ready,
  input  logic          i_clr_valid,
  input  logic [AW-1:0] i_clr_rd,
  input  logic          i_acc_a,
  input  logic [AW-1:0] i_acc_a_rd,
  input  logic          i_acc_b,
  input  logic [AW-1:0] i_acc_b_rd,
  input  logic [AW-1:0] i_q_rs1,
  input  logic [AW-1:0] i_q_rs2,
  input  logic [AW-1:0] i_q_rd,
  output logic          o_hazard,
  output logic          o_busy,
  output logic          o_err
);

  localparam int NR = 1 << AW;

  logic [NR-1:0] r_pend;
  logic [NR-1:0] w_set_mask;
  logic [NR-1:0] w_clr_mask;
  logic          w_set;

  assign o_iss_ready = (i_iss_rd == '0) | ~r_pend[i_iss_rd];
  assign w_set       = i_iss_valid & o_iss_ready & (i_iss_rd != '0);

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_set)
      w_set_mask = NR'(1) << i_iss_rd;
    if (i_clr_valid)
      w_clr_mask = NR'(1) << i_clr_rd;
  end

  // Set is applied after clear so a same-register collision leaves the bit pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else if (i_flush) begin
      r_pend <= '0;
    end else begin
      r_pend <= ((r_pend & ~w_clr_mask) | w_set_mask) & ~NR'(1);
    end
  end

  assign o_hazard = ((i_q_rs1 != '0) & r_pend[i_q_rs1]) |
                    ((i_q_rs2 != '0) & r_pend[i_q_rs2]) |
                    ((i_q_rd  != '0) & r_pend[i_q_rd]);
  assign o_busy   = |r_pend;

`ifdef RF_WB_SB_CHECK_EN
  logic r_err;
  logic w_viol;

  assign w_viol = (i_acc_b & (i_acc_b_rd != '0) & ~r_pend[i_acc_b_rd]) |
                  (i_acc_a & (i_acc_a_rd != '0) &  r_pend[i_acc_a_rd]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_viol) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  logic w_unused_chk;
  assign w_unused_chk = ^{i_acc_a, i_acc_a_rd, i_acc_b, i_acc_b_rd};
  assign o_err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// rf_wb_arbiter : round-robin write-back arbiter + scoreboard (RF_WB_SB_CHECK_EN enables sb_err)
// Revision      : 1.0
// ============================================================================
module rf_wb_arbiter #(
  parameter int XLEN   = rf_wb_pkg::XLEN,
  parameter int REG_AW = rf_wb_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_AW-1:0] a_rd,
  input  logic [XLEN-1:0]   a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_rd,
  input  logic [XLEN-1:0]   b_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  output logic              iss_ready,
  input  logic              sb_flush,
  input  logic [REG_AW-1:0] q_rs1,
  input  logic [REG_AW-1:0] q_rs2,
  input  logic [REG_AW-1:0] q_rd,
  output logic              hazard,
  output logic              sb_busy,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd_addr,
  output logic [XLEN-1:0]   rf_rd_data,
  output logic              sb_err
);

  import rf_wb_pkg::*;

  grant_e            r_prio;
  logic              r_wb_is_b;
  logic              w_acc;
  logic [REG_AW-1:0] w_wb_rd;
  logic [XLEN-1:0]   w_wb_data;

  assign a_ready   = a_valid & ~(b_valid & (r_prio == GNT_B));
  assign b_ready   = b_valid & ~(a_valid & (r_prio == GNT_A));
  assign w_acc     = a_ready | b_ready;
  assign w_wb_rd   = b_ready ? b_rd   : a_rd;
  assign w_wb_data = b_ready ? b_data : a_data;

  // Priority only rotates on contention, handing the next tie to the loser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= GNT_B;
    end else if (a_valid && b_valid) begin
      r_prio <= other_grant(r_prio);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_rd_addr <= '0;
      rf_rd_data <= '0;
      r_wb_is_b  <= 1'b0;
    end else if (w_acc) begin
      rf_we      <= (w_wb_rd != '0);
      rf_rd_addr <= w_wb_rd;
      rf_rd_data <= w_wb_data;
      r_wb_is_b  <= b_ready;
    end else begin
      rf_we      <= 1'b0;
    end
  end

  // Pending bit retires on the edge that commits the B write, not at handshake.
  rf_scoreboard #(
    .AW (REG_AW)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (sb_flush),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .o_iss_ready (iss_ready),
    .i_clr_valid (rf_we & r_wb_is_b),
    .i_clr_rd    (rf_rd_addr),
    .i_acc_a     (a_ready),
    .i_acc_a_rd  (a_rd),
    .i_acc_b     (b_ready),
    .i_acc_b_rd  (b_rd),
    .i_q_rs1     (q_rs1),
    .i_q_rs2     (q_rs2),
    .i_q_rd      (q_rd),
    .o_hazard    (hazard),
    .o_busy      (sb_busy),
    .o_err       (sb_err)
  );

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_rf_wb_arbiter;

`ifdef RF_WB_SB_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk, rst_n;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, iss_rd, q_rs1, q_rs2, q_rd, rf_rd_addr;
  logic [31:0] a_data, b_data, rf_rd_data;
  logic        iss_valid, iss_ready, sb_flush, hazard, sb_busy, rf_we, sb_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pend;
  bit          m_prio_b;
  bit          m_we, m_wb_b, m_err;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .sb_flush(sb_flush), .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
    .hazard(hazard), .sb_busy(sb_busy), .rf_we(rf_we),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = '0; m_prio_b = 1'b1; m_we = 1'b0; m_wb_b = 1'b0;
    m_err = 1'b0; m_addr = '0; m_data = '0;
  endtask

  task automatic drive_idle();
    a_valid = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0;
    iss_valid = 0; iss_rd = 0; sb_flush = 0; q_rs1 = 0; q_rs2 = 0; q_rd = 0;
  endtask

  function automatic bit m_hazard();
    return (q_rs1 != 0 && m_pend[q_rs1]) || (q_rs2 != 0 && m_pend[q_rs2]) ||
           (q_rd != 0 && m_pend[q_rd]);
  endfunction

  function automatic bit m_iss_ready();
    return (iss_rd == 0) || !m_pend[iss_rd];
  endfunction

  function automatic bit m_a_ready();
    return a_valid && !(b_valid && m_prio_b);
  endfunction

  function automatic bit m_b_ready();
    return b_valid && !(a_valid && !m_prio_b);
  endfunction

  // Advance one clock: derive the next model state from the current inputs.
  task automatic tick();
    bit acc_a, acc_b, n_we, n_wb_b, n_err, n_prio;
    logic [31:0] n_pend, n_data;
    logic [4:0]  n_addr;
    acc_a = m_a_ready();
    acc_b = m_b_ready();
    n_err = m_err;
    if (CHK) begin
      if (acc_b && b_rd != 0 && !m_pend[b_rd]) n_err = 1'b1;
      if (acc_a && a_rd != 0 &&  m_pend[a_rd]) n_err = 1'b1;
    end
    n_pend = m_pend;
    if (sb_flush) n_pend = '0;
    else begin
      if (m_we && m_wb_b) n_pend[m_addr] = 1'b0;
      if (iss_valid && m_iss_ready() && iss_rd != 0) n_pend[iss_rd] = 1'b1;
    end
    n_prio = (a_valid && b_valid) ? !m_prio_b : m_prio_b;
    n_addr = m_addr; n_data = m_data; n_wb_b = m_wb_b; n_we = 1'b0;
    if (acc_a || acc_b) begin
      n_we   = acc_b ? (b_rd != 0) : (a_rd != 0);
      n_addr = acc_b ? b_rd : a_rd;
      n_data = acc_b ? b_data : a_data;
      n_wb_b = acc_b;
    end
    @(posedge clk);
    m_pend = n_pend; m_prio_b = n_prio; m_we = n_we; m_addr = n_addr;
    m_data = n_data; m_wb_b = n_wb_b; m_err = n_err;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_we); end
    checks++; if (rf_rd_addr !== 5'd0 || rf_rd_data !== 32'd0) begin errors++; $display("FAIL reset_addr_data: got %0h/%0h want 0/0", rf_rd_addr, rf_rd_data); end
    checks++; if (sb_busy !== 1'b0 || sb_err !== 1'b0 || hazard !== 1'b0) begin errors++; $display("FAIL reset_sb: got busy=%b err=%b hz=%b want 0", sb_busy, sb_err, hazard); end
  endtask

  task automatic test_single_a();
    apply_reset();
    a_valid = 1; a_rd = 5; a_data = 32'h1234;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL single_a_ready: got a=%b b=%b want 1/0", a_ready, b_ready); end
    tick();
    drive_idle();
    #1;
    checks++; if (rf_we !== 1'b1 || rf_rd_addr !== 5'd5 || rf_rd_data !== 32'h1234) begin errors++; $display("FAIL single_a_write: got we=%b addr=%0d data=%0h want 1/5/1234", rf_we, rf_rd_addr, rf_rd_data); end
    tick();
    #1;
    checks++; if (rf_we !== 1'b0 || rf_rd_addr !== 5'd5) begin errors++; $display("FAIL single_a_after: got we=%b addr=%0d want 0/5", rf_we, rf_rd_addr); end
  endtask

  task automatic test_contention();
    apply_reset();
    a_valid = 1; a_rd = 1; a_data = 32'hA0; b_valid = 1; b_rd = 2; b_data = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (b_ready !== (i % 2 == 0) || a_ready !== (i % 2 == 1)) begin errors++; $display("FAIL contention_grant%0d: got a=%b b=%b want a=%0d b=%0d", i, a_ready, b_ready, i % 2, (i + 1) % 2); end
      if (i > 0) begin
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL contention_we%0d: got %b want 1", i, rf_we); end
      end
      tick();
    end
    drive_idle();
    #1;
    checks++; if (rf_we !== 1'b1 || rf_rd_addr !== 5'd1 || rf_rd_data !== 32'hA0) begin errors++; $display("FAIL contention_last: got we=%b addr=%0d data=%0h want 1/1/a0", rf_we, rf_rd_addr, rf_rd_data); end
    tick();
  endtask

  task automatic test_hazard();
    apply_reset();
    iss_valid = 1; iss_rd = 7; q_rs1 = 7;
    #1;
    checks++; if (iss_ready !== 1'b1 || hazard !== 1'b0) begin errors++; $display("FAIL hz_c0: got rdy=%b hz=%b want 1/0", iss_ready, hazard); end
    tick();
    #1;
    checks++; if (iss_ready !== 1'b0 || hazard !== 1'b1 || sb_busy !== 1'b1) begin errors++; $display("FAIL hz_c1: got rdy=%b hz=%b busy=%b want 0/1/1", iss_ready, hazard, sb_busy); end
    tick();
    iss_valid = 0;
    tick();
    b_valid = 1; b_rd = 7; b_data = $urandom;
    #1;
    checks++; if (b_ready !== 1'b1 || hazard !== 1'b1) begin errors++; $display("FAIL hz_c3: got brdy=%b hz=%b want 1/1", b_ready, hazard); end
    tick();
    b_valid = 0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_rd_addr !== 5'd7 || rf_rd_data !== m_data || hazard !== 1'b1) begin errors++; $display("FAIL hz_c4: got we=%b addr=%0d data=%0h hz=%b want 1/7/%0h/1", rf_we, rf_rd_addr, rf_rd_data, hazard, m_data); end
    tick();
    #1;
    checks++; if (hazard !== 1'b0 || rf_we !== 1'b0 || sb_busy !== 1'b0 || sb_err !== 1'b0) begin errors++; $display("FAIL hz_c5: got hz=%b we=%b busy=%b err=%b want 0", hazard, rf_we, sb_busy, sb_err); end
  endtask

  task automatic test_x0();
    apply_reset();
    a_valid = 1; a_rd = 0; a_data = 32'hDEAD;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b want 1", a_ready); end
    tick();
    drive_idle();
    iss_valid = 1; iss_rd = 0;
    #1;
    checks++; if (rf_we !== 1'b0 || iss_ready !== 1'b1) begin errors++; $display("FAIL x0_we: got we=%b iss_rdy=%b want 0/1", rf_we, iss_ready); end
    tick();
    iss_valid = 0;
    #1;
    checks++; if (hazard !== 1'b0 || sb_busy !== 1'b0) begin errors++; $display("FAIL x0_hazard: got hz=%b busy=%b want 0/0", hazard, sb_busy); end
  endtask

  task automatic test_flush();
    apply_reset();
    iss_valid = 1; iss_rd = 3;
    tick();
    iss_rd = 9; sb_flush = 1;
    #1;
    checks++; if (sb_busy !== 1'b1) begin errors++; $display("FAIL flush_pre: got busy=%b want 1", sb_busy); end
    tick();
    drive_idle();
    q_rs1 = 3; q_rs2 = 9;
    #1;
    checks++; if (sb_busy !== 1'b0 || hazard !== 1'b0) begin errors++; $display("FAIL flush_post: got busy=%b hz=%b want 0/0", sb_busy, hazard); end
    b_valid = 1; b_rd = 3; b_data = 32'h33;
    tick();
    drive_idle();
    tick();
    #1;
    checks++; if (sb_err !== CHK) begin errors++; $display("FAIL flush_err: got %b want %b", sb_err, CHK); end
    tick();
    #1;
    checks++; if (sb_err !== CHK) begin errors++; $display("FAIL flush_err_sticky: got %b want %b", sb_err, CHK); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    iss_valid = 1; iss_rd = 4;
    tick();
    iss_valid = 0; b_valid = 1; b_rd = 4; b_data = 32'h44;
    tick();
    b_valid = 0;
    #1;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got we=%b want 1", rf_we); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (rf_we !== 1'b0 || rf_rd_addr !== 5'd0 || rf_rd_data !== 32'd0 || sb_busy !== 1'b0) begin errors++; $display("FAIL rstmid_clear: got we=%b addr=%0d data=%0h busy=%b want 0", rf_we, rf_rd_addr, rf_rd_data, sb_busy); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1; a_rd = 1; b_valid = 1; b_rd = 2;
    #1;
    checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL rstmid_prio: got a=%b b=%b want 0/1", a_ready, b_ready); end
    drive_idle();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      a_valid = $urandom_range(0, 1); a_rd = 5'($urandom_range(0, 7)); a_data = $urandom;
      b_valid = $urandom_range(0, 1); b_rd = 5'($urandom_range(0, 7)); b_data = $urandom;
      iss_valid = ($urandom_range(0, 2) == 0); iss_rd = 5'($urandom_range(0, 7));
      sb_flush = ($urandom_range(0, 31) == 0);
      q_rs1 = 5'($urandom_range(0, 7)); q_rs2 = 5'($urandom_range(0, 7)); q_rd = 5'($urandom_range(0, 7));
      #1;
      checks++; if (a_ready !== m_a_ready() || b_ready !== m_b_ready()) begin errors++; $display("FAIL rnd_ready@%0d: got a=%b b=%b want a=%b b=%b", i, a_ready, b_ready, m_a_ready(), m_b_ready()); end
      checks++; if (iss_ready !== m_iss_ready() || hazard !== m_hazard() || sb_busy !== (m_pend != 0)) begin errors++; $display("FAIL rnd_sb@%0d: got rdy=%b hz=%b busy=%b want %b/%b/%b", i, iss_ready, hazard, sb_busy, m_iss_ready(), m_hazard(), m_pend != 0); end
      checks++; if (rf_we !== m_we || rf_rd_addr !== m_addr || rf_rd_data !== m_data) begin errors++; $display("FAIL rnd_wb@%0d: got we=%b addr=%0d data=%0h want %b/%0d/%0h", i, rf_we, rf_rd_addr, rf_rd_data, m_we, m_addr, m_data); end
      checks++; if (sb_err !== m_err) begin errors++; $display("FAIL rnd_err@%0d: got %b want %b", i, sb_err, m_err); end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_single_a();
    test_contention();
    test_hazard();
    test_x0();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
